noc_pkt_arbiter: RTL

NOC_PKT_ARBITER -- requirements
Module: noc_pkt_arbiter

---
 rtl/noc_pkt_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/noc_pkt_arbiter.sv
// noc_pkt_arbiter: packet-granular round-robin arbiter merging NREQ AXI-stream requesters onto one output.
// Define NOC_ARB_PKT_CNT_EN to add per-requester 16-bit completed-packet counters on pkt_count.
module noc_pkt_arbiter #(
    parameter int BW   = 32,
    parameter int BWB  = BW / 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_in,
    input  logic                 clk_in_rst_high,
    input  logic [NREQ-1:0]      req_TVALID,
    input  logic [NREQ*BW-1:0]   req_TDATA,
    input  logic [NREQ*BWB-1:0]  req_TKEEP,
    input  logic [NREQ-1:0]      req_TLAST,
    output logic [NREQ-1:0]      req_TREADY,
    output logic                 stream_out_TVALID,
    output logic [BW-1:0]        stream_out_TDATA,
    output logic [BWB-1:0]       stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    input  logic                 stream_out_TREADY,
    output logic [IDW-1:0]       grant_id,
`ifdef NOC_ARB_PKT_CNT_EN
    output logic                 grant_busy,
    output logic [NREQ*16-1:0]   pkt_count
`else
    output logic                 grant_busy
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    state_t          state, state_nxt;
    logic [IDW-1:0]  last_grant, last_nxt, grant_nxt, pick, off;
    logic [IDW:0]    sum;
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  chain [NREQ+1];
    logic [BW-1:0]   data_arr [NREQ];
    logic [BWB-1:0]  keep_arr [NREQ];
    logic            done;

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_lane
            assign data_arr[i] = req_TDATA[i*BW +: BW];
            assign keep_arr[i] = req_TKEEP[i*BWB +: BWB];
            assign chain[i]    = rot[i] ? IDW'(i) : chain[i+1];
        end
    endgenerate

    // rot[j] is the valid of requester (last_grant+1+j) mod NREQ; the lowest set bit wins
    assign rot      = NREQ'({req_TVALID, req_TVALID} >> ({1'b0, last_grant} + 1'b1));
    assign chain[NREQ] = '0;
    assign off      = chain[0];
    assign sum      = {1'b0, last_grant} + (IDW + 1)'(1) + {1'b0, off};
    assign pick     = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
    assign done     = (state == BUSY) & req_TVALID[grant_id] & stream_out_TREADY & req_TLAST[grant_id];
    assign grant_busy = (state == BUSY);

    always_comb begin
        state_nxt         = state;
        grant_nxt         = grant_id;
        last_nxt          = last_grant;
        req_TREADY        = '0;
        stream_out_TVALID = 1'b0;
        stream_out_TDATA  = '0;
        stream_out_TKEEP  = '0;
        stream_out_TLAST  = 1'b0;
        if (state == IDLE) begin
            state_nxt = (|req_TVALID) ? BUSY : IDLE;
            grant_nxt = (|req_TVALID) ? pick : grant_id;
        end else begin
            stream_out_TVALID = req_TVALID[grant_id];
            stream_out_TDATA  = data_arr[grant_id];
            stream_out_TKEEP  = keep_arr[grant_id];
            stream_out_TLAST  = req_TLAST[grant_id];
            req_TREADY        = NREQ'(stream_out_TREADY) << grant_id;
            state_nxt         = done ? IDLE : BUSY;
            last_nxt          = done ? grant_id : last_grant;
        end
    end

    always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
        if (clk_in_rst_high) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

`ifdef NOC_ARB_PKT_CNT_EN
    generate
        for (i = 0; i < NREQ; i++) begin : g_cnt
            logic [15:0] cnt;
            always_ff @(posedge clk_in or posedge clk_in_rst_high) begin
                if (clk_in_rst_high)
                    cnt <= '0;
                else if (done && grant_id == IDW'(i))
                    cnt <= cnt + 16'd1;
            end
            assign pkt_count[i*16 +: 16] = cnt;
        end
    endgenerate
`endif
endmodule
